// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner of the 4:1 mux select.
// Registers a one-hot grant and its binary select. A hold timer bounds how
// long one owner can keep the path while others wait.
// Optional build macro MUX_SCHED_LOCK_EN adds a `lock` input. While lock is
// high and the path is owned, hold expiry is suppressed.
module mux_rr_sched #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef MUX_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       sel_vld,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt;

    logic       owner_req;
    logic [3:0] others;
    logic [3:0] cand;
    logic       found;
    logic [1:0] win;
    logic       hold_max;
    logic       lock_hold;

`ifdef MUX_SCHED_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign owner_req = |(req & gnt);
    assign others    = req & ~gnt;
    assign hold_max  = (cnt == CNT_W'(MAX_HOLD - 1));
    assign sel_vld   = |gnt;
    assign busy      = (state == OWN);

    // While the owner still wants the path, only the others compete. On
    // release or from idle the owner bit is already clear, so raw req is used.
    assign cand = owner_req ? others : req;

    // Pick the first set candidate bit, starting at the pointer and wrapping.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!found && cand[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

    // Scheduler state machine. It owns every registered output and the
    // pointer and hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= OWN;
                        gnt   <= 4'b0001 << win;
                        sel   <= win;
                        ptr   <= win + 2'd1;
                        cnt   <= '0;
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        // Release: hand over with no idle bubble, or go idle.
                        if (found) begin
                            gnt <= 4'b0001 << win;
                            sel <= win;
                            ptr <= win + 2'd1;
                            cnt <= '0;
                        end else begin
                            gnt   <= 4'b0000;
                            state <= IDLE;
                        end
                    end else if (hold_max && (|others) && !lock_hold) begin
                        // Hold expiry: force the path to the next waiter.
                        gnt     <= 4'b0001 << win;
                        sel     <= win;
                        ptr     <= win + 2'd1;
                        cnt     <= '0;
                        preempt <= 1'b1;
                    end else if (!hold_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
